// File: rtl/dma_xfer_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Package : dma_pkg
// Shared sequencer state type, cache-line size and err bit positions.
// Rev     : 1.0
// ============================================================================
package dma_pkg;

    localparam int CL_BYTES    = 64;
    localparam int ERR_TIMEOUT = 0;
    localparam int ERR_ALIGN   = 1;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_LOAD_START  = 3'd1,
        ST_LOAD_WAIT   = 3'd2,
        ST_RUN         = 3'd3,
        ST_STORE_START = 3'd4,
        ST_STORE_WAIT  = 3'd5,
        ST_DONE        = 3'd6
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/dma_xfer_sequencer_line_counter.sv
`default_nettype none
// ============================================================================
// Module : dma_line_counter
// Saturating per-phase line counter; hit flags the pulse that reaches target.
// Rev    : 1.0
// ============================================================================
module dma_line_counter
    import dma_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc,
    input  logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] count,
    output logic             hit
);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;

    always_comb begin
        w_count_nxt = r_count;
        if (inc && (r_count != {WIDTH{1'b1}})) begin
            w_count_nxt = r_count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_nxt;
        end
    end

    // Looks at the post-increment value so the phase ends on the final pulse.
    assign hit   = (w_count_nxt >= target);
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/dma_xfer_sequencer.sv
`default_nettype none
// ============================================================================
// Module : dma_xfer_sequencer
// Host command -> LOAD -> RUN (CPU out of reset) -> STORE -> DONE controller.
// Rev    : 1.0
// ============================================================================
module dma_xfer_sequencer
    import dma_pkg::*;
#(
    parameter int ADDR_WIDTH    = 32,
    parameter int LEN_WIDTH     = 16,
    parameter int CL_BYTES      = dma_pkg::CL_BYTES,
    parameter int TIMEOUT_WIDTH = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [ADDR_WIDTH-1:0]    cmd_load_addr,
    input  logic [LEN_WIDTH-1:0]     cmd_load_lines,
    input  logic [ADDR_WIDTH-1:0]    cmd_store_addr,
    input  logic [LEN_WIDTH-1:0]     cmd_store_lines,
    input  logic [TIMEOUT_WIDTH-1:0] cmd_timeout,
    output logic                     eng_load_start,
    output logic                     eng_store_start,
    output logic [ADDR_WIDTH-1:0]    eng_base_addr,
    input  logic                     eng_line_done,
    output logic                     cpu_rst_n,
    input  logic                     cpu_halt,
    output logic                     busy,
    output logic                     done,
    output logic [1:0]               err,
    output logic [LEN_WIDTH:0]       lines_moved
);

    localparam logic [ADDR_WIDTH-1:0] c_OFF_MASK = ADDR_WIDTH'(CL_BYTES - 1);

    seq_state_t               r_state;
    seq_state_t               w_state_nxt;
    logic                     w_timeout_hit;

    logic                     r_cmd_ready;
    logic                     r_busy;
    logic                     r_cpu_rst_n;
    logic                     r_load_start;
    logic                     r_store_start;
    logic                     r_done;
    logic [ADDR_WIDTH-1:0]    r_base_addr;
    logic [1:0]               r_err;
    logic [LEN_WIDTH:0]       r_lines_moved;

    logic [LEN_WIDTH-1:0]     r_load_lines;
    logic [LEN_WIDTH-1:0]     r_store_lines;
    logic [ADDR_WIDTH-1:0]    r_store_addr;
    logic [TIMEOUT_WIDTH-1:0] r_timeout;
    logic [TIMEOUT_WIDTH-1:0] r_wd;
    logic [TIMEOUT_WIDTH-1:0] w_wd_nxt;
    logic                     w_wd_expire;

    logic                     w_accept;
    logic                     w_misaligned;
    logic                     w_load_phase;
    logic                     w_counting;
    logic                     w_line_inc;
    logic                     w_line_inc_eff;
    logic                     w_line_clear;
    logic [LEN_WIDTH-1:0]     w_line_target;
    logic [LEN_WIDTH-1:0]     w_line_count;
    logic                     w_line_hit;

    assign w_accept     = cmd_valid && r_cmd_ready;
    assign w_misaligned = ((cmd_load_addr & c_OFF_MASK) != '0) ||
                          ((cmd_store_addr & c_OFF_MASK) != '0);

    assign w_load_phase  = (r_state == ST_LOAD_START) || (r_state == ST_LOAD_WAIT);
    assign w_counting    = w_load_phase ||
                           (r_state == ST_STORE_START) || (r_state == ST_STORE_WAIT);
    assign w_line_inc    = eng_line_done && w_counting;
    assign w_line_target = w_load_phase ? r_load_lines : r_store_lines;
    assign w_line_clear  = w_accept || ((r_state == ST_RUN) && (w_state_nxt == ST_STORE_START));
    // A saturated phase counter also freezes the total, so lines_moved cannot wrap.
    assign w_line_inc_eff = w_line_inc && (w_line_count != {LEN_WIDTH{1'b1}});

    assign w_wd_nxt    = (r_wd == {TIMEOUT_WIDTH{1'b1}}) ? r_wd : r_wd + 1'b1;
    assign w_wd_expire = (r_timeout != '0) && (w_wd_nxt == r_timeout);

    dma_line_counter #(
        .WIDTH (LEN_WIDTH)
    ) u_line_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (w_line_clear),
        .inc    (w_line_inc),
        .target (w_line_target),
        .count  (w_line_count),
        .hit    (w_line_hit)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_timeout_hit = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_misaligned) begin
                        w_state_nxt = ST_DONE;
                    end else if (cmd_load_lines == '0) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_state_nxt = ST_LOAD_START;
                    end
                end
            end
            ST_LOAD_START: w_state_nxt = ST_LOAD_WAIT;
            ST_LOAD_WAIT: begin
                if (w_line_hit) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                // Halt takes priority over a watchdog expiry in the same cycle.
                if (cpu_halt) begin
                    w_state_nxt = (r_store_lines == '0) ? ST_DONE : ST_STORE_START;
                end else if (w_wd_expire) begin
                    w_state_nxt   = ST_DONE;
                    w_timeout_hit = 1'b1;
                end
            end
            ST_STORE_START: w_state_nxt = ST_STORE_WAIT;
            ST_STORE_WAIT: begin
                if (w_line_hit) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_cmd_ready   <= 1'b1;
            r_busy        <= 1'b0;
            r_cpu_rst_n   <= 1'b0;
            r_load_start  <= 1'b0;
            r_store_start <= 1'b0;
            r_done        <= 1'b0;
            r_base_addr   <= '0;
            r_err         <= '0;
            r_lines_moved <= '0;
            r_load_lines  <= '0;
            r_store_lines <= '0;
            r_store_addr  <= '0;
            r_timeout     <= '0;
            r_wd          <= '0;
        end else begin
            r_state       <= w_state_nxt;
            // Status outputs are decoded from the next state so they align with it.
            r_cmd_ready   <= (w_state_nxt == ST_IDLE);
            r_busy        <= (w_state_nxt != ST_IDLE);
            r_cpu_rst_n   <= (w_state_nxt == ST_RUN);
            r_load_start  <= (w_state_nxt == ST_LOAD_START);
            r_store_start <= (w_state_nxt == ST_STORE_START);
            r_done        <= (w_state_nxt == ST_DONE);
            r_wd          <= (r_state == ST_RUN) ? w_wd_nxt : '0;

            if (w_accept) begin
                r_load_lines          <= cmd_load_lines;
                r_store_lines         <= cmd_store_lines;
                r_store_addr          <= cmd_store_addr;
                r_timeout             <= cmd_timeout;
                r_lines_moved         <= '0;
                r_err                 <= '0;
                r_err[ERR_ALIGN]      <= w_misaligned;
            end else begin
                if (w_timeout_hit) begin
                    r_err[ERR_TIMEOUT] <= 1'b1;
                end
                if (w_line_inc_eff) begin
                    r_lines_moved <= r_lines_moved + 1'b1;
                end
            end

            if (w_state_nxt == ST_LOAD_START) begin
                r_base_addr <= cmd_load_addr;
            end else if (w_state_nxt == ST_STORE_START) begin
                r_base_addr <= r_store_addr;
            end
        end
    end

    assign cmd_ready       = r_cmd_ready;
    assign busy            = r_busy;
    assign cpu_rst_n       = r_cpu_rst_n;
    assign eng_load_start  = r_load_start;
    assign eng_store_start = r_store_start;
    assign done            = r_done;
    assign eng_base_addr   = r_base_addr;
    assign err             = r_err;
    assign lines_moved     = r_lines_moved;

endmodule
`default_nettype wire

// File: tb/tb_dma_xfer_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_dma_xfer_sequencer
// Table-driven scoreboard bench with engine/CPU responders and reset corners.
// Rev    : 1.0
// ============================================================================
module tb_dma_xfer_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_load_addr = '0;
    logic [15:0] cmd_load_lines = '0;
    logic [31:0] cmd_store_addr = '0;
    logic [15:0] cmd_store_lines = '0;
    logic [23:0] cmd_timeout = '0;
    logic        eng_load_start;
    logic        eng_store_start;
    logic [31:0] eng_base_addr;
    logic        eng_line_done = 1'b0;
    logic        cpu_rst_n;
    logic        cpu_halt = 1'b0;
    logic        busy;
    logic        done;
    logic [1:0]  err;
    logic [16:0] lines_moved;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic [31:0] load_addr;
        logic [15:0] load_lines;
        logic [31:0] store_addr;
        logic [15:0] store_lines;
        logic [23:0] timeout;
        int          halt_at;     // RUN cycles before cpu_halt rises; 0 = never
        int          eng_delay;   // engine idle cycles after a start pulse
        bit          stray;       // extra eng_line_done in RUN and in IDLE
        logic [1:0]  exp_err;
        logic [16:0] exp_lines;
        int          exp_ls;
        int          exp_ss;
        int          exp_run_lo;
        int          exp_run_hi;
        int          budget;
    } vec_t;

    vec_t vecs[9];
    vec_t exp_q[$];

    dma_xfer_sequencer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_load_addr   (cmd_load_addr),
        .cmd_load_lines  (cmd_load_lines),
        .cmd_store_addr  (cmd_store_addr),
        .cmd_store_lines (cmd_store_lines),
        .cmd_timeout     (cmd_timeout),
        .eng_load_start  (eng_load_start),
        .eng_store_start (eng_store_start),
        .eng_base_addr   (eng_base_addr),
        .eng_line_done   (eng_line_done),
        .cpu_rst_n       (cpu_rst_n),
        .cpu_halt        (cpu_halt),
        .busy            (busy),
        .done            (done),
        .err             (err),
        .lines_moved     (lines_moved)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_vec++;
        if (act !== want) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_vec++;
        if (act < lo || act > hi) begin
            n_miss++;
            $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_cpu_rst_n"}, cpu_rst_n, 0);
        check({tag, "_load_start"}, eng_load_start, 0);
        check({tag, "_store_start"}, eng_store_start, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_base_addr"}, eng_base_addr, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_lines_moved"}, lines_moved, 0);
    endtask

    // Cycle (counted from the accept edge) at which RUN is first visible.
    function automatic int exp_first_run(input vec_t v);
        int t;
        if (v.load_addr[5:0] != 6'd0 || v.store_addr[5:0] != 6'd0) return -1;
        if (v.load_lines == 16'd0) return 1;
        t = v.eng_delay + int'(v.load_lines) + 1;
        return (t < 3) ? 3 : t;
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        vec_t        e;
        int          cyc = 0;
        int          ls = 0;
        int          ss = 0;
        int          run_cnt = 0;
        int          first_run = -1;
        int          pend = 0;
        int          wait_c = 0;
        bit          done_seen = 0;
        logic [31:0] ls_addr = '0;
        logic [31:0] ss_addr = '0;
        string       p;
        p = $sformatf("v%0d", idx);

        @(negedge clk);
        check({p, "_ready_before"}, cmd_ready, 1);
        cmd_load_addr   = v.load_addr;
        cmd_load_lines  = v.load_lines;
        cmd_store_addr  = v.store_addr;
        cmd_store_lines = v.store_lines;
        cmd_timeout     = v.timeout;
        cmd_valid       = 1'b1;
        exp_q.push_back(v);

        while (!done_seen && cyc < v.budget) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            cmd_valid     = 1'b0;
            eng_line_done = 1'b0;
            if (cyc == 1) check({p, "_ready_after_accept"}, cmd_ready, 0);
            if (eng_load_start) begin
                ls++; ls_addr = eng_base_addr; pend = int'(v.load_lines); wait_c = v.eng_delay;
            end
            if (eng_store_start) begin
                ss++; ss_addr = eng_base_addr; pend = int'(v.store_lines); wait_c = v.eng_delay;
            end
            if (wait_c > 0) begin
                wait_c--;
            end else if (pend > 0) begin
                eng_line_done = 1'b1;
                pend--;
            end
            if (cpu_rst_n) begin
                run_cnt++;
                if (first_run < 0) first_run = cyc;
                if (v.halt_at > 0 && run_cnt >= v.halt_at) cpu_halt = 1'b1;
                if (v.stray && run_cnt == 2) eng_line_done = 1'b1;
            end else begin
                cpu_halt = 1'b0;
            end
            if (done) begin
                done_seen = 1;
                e = exp_q.pop_front();
                check({p, "_err"}, err, e.exp_err);
                check({p, "_lines_moved"}, lines_moved, e.exp_lines);
                check({p, "_load_starts"}, ls, e.exp_ls);
                check({p, "_store_starts"}, ss, e.exp_ss);
                if (e.exp_ls > 0) check({p, "_load_base"}, ls_addr, e.load_addr);
                if (e.exp_ss > 0) check({p, "_store_base"}, ss_addr, e.store_addr);
                check_range({p, "_run_cycles"}, run_cnt, e.exp_run_lo, e.exp_run_hi);
                check({p, "_first_run_cycle"}, first_run, exp_first_run(e));
                check({p, "_cpu_rst_n_at_done"}, cpu_rst_n, 0);
            end
        end

        eng_line_done = 1'b0;
        cpu_halt      = 1'b0;
        if (!done_seen) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s_done_timeout: got no done in %0d cycles, want done", p, v.budget);
            void'(exp_q.pop_front());
            return;
        end

        @(negedge clk);
        check({p, "_done_one_cycle"}, done, 0);
        check({p, "_idle_ready"}, cmd_ready, 1);
        check({p, "_err_held"}, err, v.exp_err);

        if (v.stray) begin
            eng_line_done = 1'b1;
            @(negedge clk);
            eng_line_done = 1'b0;
            @(negedge clk);
            check({p, "_idle_stray_lines"}, lines_moved, v.exp_lines);
            check({p, "_idle_stray_busy"}, busy, 0);
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        //          load_addr     ll     store_addr    sl     to      halt dly st  err    lines   ls ss lo   hi   budget
        vecs[0] = '{32'h0000_1000, 16'd4, 32'h0000_2000, 16'd2, 24'd0,   10, 1, 1'b0, 2'b00, 17'd6, 1, 1, 10,  11,  200};
        vecs[1] = '{32'h0000_0000, 16'd0, 32'h0000_0000, 16'd0, 24'd0,   5,  0, 1'b0, 2'b00, 17'd0, 0, 0, 5,   6,   100};
        vecs[2] = '{32'h0000_0000, 16'd0, 32'h0000_3000, 16'd3, 24'd100, 0,  0, 1'b0, 2'b01, 17'd0, 0, 0, 98,  102, 300};
        vecs[3] = '{32'h0000_1004, 16'd4, 32'h0000_2000, 16'd2, 24'd0,   5,  0, 1'b0, 2'b10, 17'd0, 0, 0, 0,   0,   2};
        vecs[4] = '{32'h0000_1000, 16'd4, 32'h0000_2020, 16'd2, 24'd0,   5,  0, 1'b0, 2'b10, 17'd0, 0, 0, 0,   0,   2};
        vecs[5] = '{32'h0000_0040, 16'd1, 32'h0000_0080, 16'd2, 24'd5,   5,  0, 1'b0, 2'b00, 17'd3, 1, 1, 5,   6,   100};
        vecs[6] = '{32'h0000_0100, 16'd2, 32'h0000_0200, 16'd1, 24'd0,   6,  2, 1'b1, 2'b00, 17'd3, 1, 1, 6,   7,   100};
        vecs[7] = '{32'h0004_0000, 16'd1, 32'h0000_0000, 16'd0, 24'd50,  3,  0, 1'b0, 2'b00, 17'd1, 1, 0, 3,   4,   100};
        vecs[8] = '{32'h0000_0001, 16'd2, 32'h0000_0003, 16'd2, 24'd9,   5,  0, 1'b0, 2'b10, 17'd0, 0, 0, 0,   0,   2};

        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("post_reset");

        // Stray engine pulses while idle must not count.
        eng_line_done = 1'b1;
        @(negedge clk);
        @(negedge clk);
        eng_line_done = 1'b0;
        @(negedge clk);
        check("idle_stray_lines", lines_moved, 0);
        check("idle_stray_busy", busy, 0);

        // Second command during LOAD_WAIT is refused, then reset mid-load.
        cmd_load_addr   = 32'h0000_1000;
        cmd_load_lines  = 16'd4;
        cmd_store_addr  = 32'h0000_2000;
        cmd_store_lines = 16'd2;
        cmd_timeout     = 24'd0;
        cmd_valid       = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("mid_load_start", eng_load_start, 1);
        check("mid_busy", busy, 1);
        @(negedge clk);
        cmd_load_addr = 32'h0000_5000;
        cmd_valid     = 1'b1;
        eng_line_done = 1'b1;
        @(negedge clk);
        check("mid_ready_busy", cmd_ready, 0);
        check("mid_no_restart", eng_load_start, 0);
        check("mid_lines1", lines_moved, 1);
        @(negedge clk);
        check("mid_lines2", lines_moved, 2);
        check("mid_no_done", done, 0);
        eng_line_done = 1'b0;
        cmd_valid     = 1'b0;
        rst_n         = 1'b0;
        #1;
        check_reset_vals("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("after_reset_quiet_done%0d", i), done, 0);
            check($sformatf("after_reset_quiet_start%0d", i), eng_load_start, 0);
        end
        check("after_reset_ready", cmd_ready, 1);
        check("after_reset_busy", busy, 0);

        for (int i = 0; i < 9; i++) begin
            run_vec(i, vecs[i]);
        end

        check("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dma_xfer_sequencer.md
Name: dma_xfer_sequencer

Overview:
- Top-level transfer controller for the host↔accelerator DMA word engine.
- Accepts one host command, then sequences four phases in order:
  - LOAD: commands the engine to move N cache lines from host into accelerator memory at a base address.
  - RUN: releases the CPU from reset and waits for it to halt.
  - STORE: commands the engine to return M lines from a second base address to the host.
  - DONE: reports completion.
- Sits between the host CSR interface, the DMA word engine and the CPU reset/halt pins.

Parameters:
- ADDR_WIDTH, 32, byte address width of accelerator memory.
- LEN_WIDTH, 16, width of line-count fields.
- CL_BYTES, 64, bytes per cache line; base addresses must be CL_BYTES aligned.
- TIMEOUT_WIDTH, 24, width of the RUN-phase watchdog counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_load_addr  in  ADDR_WIDTH  LOAD base address.
- cmd_load_lines  in  LEN_WIDTH  lines to load; 0 means skip LOAD.
- cmd_store_addr  in  ADDR_WIDTH  STORE base address.
- cmd_store_lines  in  LEN_WIDTH  lines to store; 0 means skip STORE.
- cmd_timeout  in  TIMEOUT_WIDTH  RUN watchdog limit in cycles; 0 disables the watchdog.
- eng_load_start  out  1  one-cycle pulse starting an engine LOAD.
- eng_store_start  out  1  one-cycle pulse starting an engine STORE.
- eng_base_addr  out  ADDR_WIDTH  base address for the engine; stable from the start pulse until the phase ends.
- eng_line_done  in  1  engine pulse, one per completed line, either direction.
- cpu_rst_n  out  1  CPU reset, active-low.
- cpu_halt  in  1  CPU finished (level).
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  2  status: bit0 watchdog timeout, bit1 misaligned address; valid with done and held until the next accept.
- lines_moved  out  LEN_WIDTH+1  total lines counted in the last command.

Behaviour:
- Reset is asynchronous, active-low, on rst_n; clock is clk. All outputs register-driven.
- Reset values:
  - cmd_ready=1, cpu_rst_n=0, busy=0.
  - eng_load_start=0, eng_store_start=0, done=0.
  - eng_base_addr=0, err=0, lines_moved=0.
  - State IDLE.
- States are IDLE, LOAD_START, LOAD_WAIT, RUN, STORE_START, STORE_WAIT, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, capture all cmd fields; clear err, lines_moved and the line counter; cmd_ready falls the next cycle.
  - If either address has nonzero bits in [log2(CL_BYTES)-1:0], set err[1] and go to DONE.
  - Otherwise go to LOAD_START, or to RUN if load_lines==0.
- LOAD_START:
  - Exactly one cycle; eng_load_start=1 and eng_base_addr=load_addr.
  - Next state LOAD_WAIT.
- LOAD_WAIT:
  - Each eng_line_done increments the line counter and lines_moved.
  - When the counter reaches load_lines, with the pulse that reaches it, go to RUN next cycle.
  - An eng_line_done arriving in the same cycle as eng_load_start is counted.
- RUN:
  - cpu_rst_n=1 from the first RUN cycle.
  - The watchdog counts cycles from 0.
  - If cpu_halt is sampled high, go to STORE_START, or to DONE if store_lines==0.
  - If cmd_timeout!=0 and the watchdog reaches cmd_timeout with cpu_halt low, set err[0] and go to DONE; STORE is skipped.
  - If cpu_halt and timeout occur in the same cycle, halt wins and no error is raised.
- STORE_START / STORE_WAIT: same as LOAD with store_addr, store_lines and eng_store_start; the line counter is cleared on entry.
- DONE:
  - done=1 for exactly one cycle; cpu_rst_n returns to 0 in the same cycle.
  - Next state IDLE.
- eng_line_done in IDLE, RUN or DONE is ignored and does not count.
- Line counters saturate; they never wrap.
- cmd_valid while busy is ignored; no queueing.
- rst_n asserted mid-operation returns all outputs to reset values immediately; the CPU is held in reset and no done pulse is issued.

Decomposition:
- Shared package dma_pkg holds:
  - the sequencer state enum type;
  - CL_BYTES;
  - the err bit-index constants ERR_TIMEOUT=0 and ERR_ALIGN=1.
- Sub-module dma_line_counter holds the line-count logic, instantiated once and reused by both phases. Its interface is clear, inc and target in; count and hit out.

Test Plan:
- Nominal:
  - Stimulus: load 0x1000/4 lines, store 0x2000/2 lines, timeout 0; engine pulses 4 lines; cpu_halt raised 10 cycles into RUN; engine pulses 2 lines.
  - Response: one eng_load_start with eng_base_addr=0x1000; cpu_rst_n high for 10–11 cycles; one eng_store_start with 0x2000; done pulse; err=0; lines_moved=6.
- Skip phases:
  - Stimulus: load_lines=0, store_lines=0.
  - Response: no engine start pulses; RUN is entered 1 cycle after accept; done follows cpu_halt; lines_moved=0.
- Watchdog:
  - Stimulus: timeout=100, cpu_halt never rises.
  - Response: done about 100 cycles after RUN entry; err=2'b01; no eng_store_start; cpu_rst_n=0 after done.
- Alignment error:
  - Stimulus: cmd_load_addr=0x1004.
  - Response: done within 2 cycles; err=2'b10; cpu_rst_n never rises; no engine start pulses.
- Mid-transfer reset plus busy rejection:
  - Stimulus: send a second cmd_valid during LOAD_WAIT, then assert rst_n after 2 of 4 lines.
  - Response: the second command is not accepted (cmd_ready=0); after reset all outputs are at reset values, with no done pulse and cmd_ready=1.
- Stray pulses:
  - Stimulus: eng_line_done pulses in IDLE and RUN.
  - Response: lines_moved is unchanged and the state sequence is unaffected.
